// File: rtl/spart_rx_if.sv
// spart_rx_if -- host-side read interface of the SPART receiver.
//
// Signals:
//   rd_en      host -> receiver  single-cycle read strobe, acknowledges the held byte
//   rx_data    receiver -> host  last received byte
//   rda        receiver -> host  receive data available
//   frame_err  receiver -> host  stop bit of the held byte was sampled low
//   overrun    receiver -> host  a byte completed while rda was already set
//
// Modports:
//   master  the receiver (drives the status/data outputs)
//   slave   the host (drives the read strobe)
interface spart_rx_if;
    logic       rd_en;
    logic [7:0] rx_data;
    logic       rda;
    logic       frame_err;
    logic       overrun;

    modport master (
        input  rd_en,
        output rx_data,
        output rda,
        output frame_err,
        output overrun
    );

    modport slave (
        output rd_en,
        input  rx_data,
        input  rda,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/spart_rx.sv
// spart_rx -- UART-style serial receiver with 16x oversampling.
//
// A programmable tick generator produces sample ticks every divisor+1 clocks;
// one bit time is 16 ticks. The receiver hunts for a start bit, confirms it at
// mid-bit, samples 8 data bits LSB-first at mid-bit, samples the stop bit and
// then delivers the byte with data-available, framing-error and overrun flags.
//
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous active-low reset
//   rxd      serial receive line, idle high, asynchronous to clk
//   divisor  sample-tick period minus one, in clk cycles
//   bus      spart_rx_if.master: rd_en in; rx_data, rda, frame_err, overrun out
//
// Parameter:
//   SYNC_STAGES  number of synchronizer flops on rxd (2 or 3)
module spart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] divisor,
    spart_rx_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;

    logic [15:0] tick_cnt;
    logic        tick;

    state_t      state, state_next;
    logic [3:0]  sample_cnt, sample_next;
    logic [2:0]  bit_cnt, bit_next;
    logic        armed, armed_next;
    logic [7:0]  shift_q, shift_next;
    logic        complete;

    logic [7:0]  data_q;
    logic        rda_q;
    logic        frame_err_q;
    logic        overrun_q;

    // Synchronizer resets to the idle (high) line level so reset release
    // never looks like a falling start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Down counter: the cycle it reads zero is a tick and it reloads, so a new
    // divisor only takes effect at the next reload.
    assign tick = (tick_cnt == 16'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= 16'd0;
        end else if (tick) begin
            tick_cnt <= divisor;
        end else begin
            tick_cnt <= tick_cnt - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sample_cnt <= 4'd0;
            bit_cnt    <= 3'd0;
            armed      <= 1'b0;
            shift_q    <= 8'h00;
        end else begin
            state      <= state_next;
            sample_cnt <= sample_next;
            bit_cnt    <= bit_next;
            armed      <= armed_next;
            shift_q    <= shift_next;
        end
    end

    // Receive sequencing. Nothing moves except on tick cycles. armed must be
    // re-established by an idle-high tick after every frame, so a break (line
    // stuck low) can never be taken as a fresh start bit.
    always_comb begin
        state_next  = state;
        sample_next = sample_cnt;
        bit_next    = bit_cnt;
        armed_next  = armed;
        shift_next  = shift_q;
        complete    = 1'b0;

        if (tick) begin
            case (state)
                IDLE: begin
                    if (rxd_s) begin
                        armed_next = 1'b1;
                    end else if (armed) begin
                        state_next  = START;
                        sample_next = 4'd0;
                        armed_next  = 1'b0;
                    end
                end

                // The 8th tick lands mid start bit; a high line there is a glitch.
                START: begin
                    if (sample_cnt == 4'd7) begin
                        if (!rxd_s) begin
                            state_next  = DATA;
                            sample_next = 4'd0;
                            bit_next    = 3'd0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        sample_next = sample_cnt + 4'd1;
                    end
                end

                // Sample counter wraps 15 -> 0, so each bit sample lands 16
                // ticks after the previous mid-bit point.
                DATA: begin
                    sample_next = sample_cnt + 4'd1;
                    if (sample_cnt == 4'd15) begin
                        shift_next = {rxd_s, shift_q[7:1]};
                        bit_next   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_next = STOP;
                        end
                    end
                end

                STOP: begin
                    sample_next = sample_cnt + 4'd1;
                    if (sample_cnt == 4'd15) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Host-visible holding register. A completing byte always wins over a
    // read; a read on the same cycle only suppresses the overrun it would
    // otherwise cause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q      <= 8'h00;
            rda_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (complete) begin
            data_q      <= shift_q;
            rda_q       <= 1'b1;
            frame_err_q <= ~rxd_s;
            overrun_q   <= bus.rd_en ? 1'b0 : (overrun_q | rda_q);
        end else if (bus.rd_en && rda_q) begin
            rda_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rda       = rda_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx -- self-checking bench for spart_rx.
//
// Serial frames are driven on rxd cycle by cycle; a behavioural model of the
// host-visible registers predicts rx_data/rda/frame_err/overrun from the
// frames sent and the reads issued.
module tb_spart_rx;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic [15:0] divisor = 16'd0;

    spart_rx_if bus ();

    spart_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .divisor (divisor),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected host-visible state.
    logic       exp_rda  = 1'b0;
    logic       exp_fe   = 1'b0;
    logic       exp_ov   = 1'b0;
    logic [7:0] exp_data = 8'h00;

    function automatic void model_complete(input logic [7:0] b, input logic stop_bit,
                                           input logic same_cycle_read);
        if (same_cycle_read) exp_ov = 1'b0;
        else                 exp_ov = exp_ov | exp_rda;
        exp_rda  = 1'b1;
        exp_data = b;
        exp_fe   = ~stop_bit;
    endfunction

    function automatic void model_read();
        if (exp_rda) begin
            exp_rda = 1'b0;
            exp_fe  = 1'b0;
            exp_ov  = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        exp_rda  = 1'b0;
        exp_fe   = 1'b0;
        exp_ov   = 1'b0;
        exp_data = 8'h00;
    endfunction

    function automatic int bit_len();
        return 16 * (int'(divisor) + 1);
    endfunction

    task automatic idle_bits(input int nbits);
        for (int c = 0; c < nbits * bit_len(); c++) begin
            @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    task automatic pulse_read();
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        model_read();
    endtask

    // Drives start, 8 data bits LSB-first and the stop bit. rd_en is raised
    // for the single cycle preceding clock edge number read_at (counted from
    // the edge that first sees the start bit). rise_at reports the first
    // sampling point at which rda was seen going 0 -> 1, or -1.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int read_at, output int rise_at);
        int         blen;
        logic [9:0] frame;
        logic       prev;
        blen    = bit_len();
        frame   = {stop_bit, b, 1'b0};
        rise_at = -1;
        prev    = bus.rda;
        for (int c = 0; c < 10 * blen; c++) begin
            @(negedge clk);
            if (rise_at < 0 && !prev && bus.rda === 1'b1) rise_at = c;
            prev      = bus.rda;
            rxd       = frame[c / blen];
            bus.rd_en = (c == read_at);
        end
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        rxd       = 1'b1;
        bus.rd_en = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL reset_held: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL reset_release: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
    endtask

    task automatic test_basic();
        int rise;
        int p;
        divisor = 16'd1;
        p = 2;
        idle_bits(2);
        send_frame(8'hA5, 1'b1, -1, rise);
        model_complete(8'hA5, 1'b1, 1'b0);
        idle_bits(1);
        total++;
        if (rise < SYNC + 152 * p + 1 || rise > SYNC + 153 * p) begin
            bad++;
            $display("[TB] FAIL basic_latency: rda rose at cycle %0d want %0d..%0d",
                     rise, SYNC + 152 * p + 1, SYNC + 153 * p);
        end
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL basic_a5: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
    endtask

    task automatic test_glitch();
        divisor = 16'd1;
        pulse_read();
        idle_bits(2);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rxd = 1'b0;
        end
        idle_bits(3);
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL glitch_reject: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
    endtask

    task automatic test_break();
        int rise;
        divisor = 16'd0;
        pulse_read();
        idle_bits(2);
        send_frame(8'h3C, 1'b0, -1, rise);
        model_complete(8'h3C, 1'b0, 1'b0);
        total++;
        if (rise != SYNC + 153) begin
            bad++;
            $display("[TB] FAIL break_latency: rda rose at cycle %0d want %0d", rise, SYNC + 153);
        end
        for (int c = 0; c < 40 * bit_len(); c++) begin
            @(negedge clk);
            rxd = 1'b0;
        end
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL break_byte: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
        pulse_read();
        for (int c = 0; c < 12 * bit_len(); c++) begin
            @(negedge clk);
            rxd = 1'b0;
        end
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL break_no_second: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
        idle_bits(2);
    endtask

    task automatic test_overrun();
        int rise;
        divisor = 16'd1;
        pulse_read();
        idle_bits(2);
        send_frame(8'h11, 1'b1, -1, rise);
        model_complete(8'h11, 1'b1, 1'b0);
        idle_bits(2);
        send_frame(8'h22, 1'b1, -1, rise);
        model_complete(8'h22, 1'b1, 1'b0);
        idle_bits(1);
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL overrun_set: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
        pulse_read();
        @(negedge clk);
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL overrun_clear: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
    endtask

    task automatic test_back_to_back_read();
        int rise;
        divisor = 16'd0;
        // Read strobe with nothing held must leave everything alone.
        pulse_read();
        pulse_read();
        @(negedge clk);
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL idle_read: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
        idle_bits(2);
        send_frame(8'h11, 1'b1, -1, rise);
        model_complete(8'h11, 1'b1, 1'b0);
        idle_bits(2);
        // With divisor 0 the byte completes on the edge SYNC+152 after the
        // start bit is first clocked in.
        send_frame(8'h7E, 1'b1, SYNC + 152, rise);
        model_complete(8'h7E, 1'b1, 1'b1);
        idle_bits(1);
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL coincident_read: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        int rise;
        int p;
        divisor = 16'd1;
        p = 2;
        pulse_read();
        idle_bits(2);
        for (int c = 0; c < 4 * bit_len(); c++) begin
            @(negedge clk);
            rxd = (c < bit_len()) ? 1'b0 : 1'b1;
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        model_reset();
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL midreset_cleared: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
        rst = 1'b1;
        idle_bits(12);
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL midreset_no_partial: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
        send_frame(8'h81, 1'b1, -1, rise);
        model_complete(8'h81, 1'b1, 1'b0);
        idle_bits(1);
        total++;
        if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
            bad++;
            $display("[TB] FAIL midreset_next_byte: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                     bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
        end
    endtask

    task automatic test_random();
        int         rise;
        int         p;
        logic [7:0] b;
        logic       stop_bit;
        logic       was_rda;
        for (int i = 0; i < 8; i++) begin
            divisor  = 16'($urandom_range(0, 3));
            p        = int'(divisor) + 1;
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            idle_bits(2);
            was_rda = exp_rda;
            send_frame(b, stop_bit, -1, rise);
            model_complete(b, stop_bit, 1'b0);
            idle_bits(1);
            if (!was_rda) begin
                total++;
                if (rise < SYNC + 152 * p + 1 || rise > SYNC + 153 * p) begin
                    bad++;
                    $display("[TB] FAIL random_latency[%0d]: rda rose at cycle %0d want %0d..%0d",
                             i, rise, SYNC + 152 * p + 1, SYNC + 153 * p);
                end
            end
            total++;
            if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
                bad++;
                $display("[TB] FAIL random_frame[%0d]: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                         i, bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
            end
            if ($urandom_range(0, 1) == 1) begin
                pulse_read();
                @(negedge clk);
                total++;
                if ({bus.rda, bus.frame_err, bus.overrun, bus.rx_data} !== {exp_rda, exp_fe, exp_ov, exp_data}) begin
                    bad++;
                    $display("[TB] FAIL random_read[%0d]: got rda/fe/ov/data=%b/%b/%b/%h want %b/%b/%b/%h",
                             i, bus.rda, bus.frame_err, bus.overrun, bus.rx_data, exp_rda, exp_fe, exp_ov, exp_data);
                end
            end
        end
    endtask

    initial begin
        bus.rd_en = 1'b0;
        $display("[TB] spart_rx bench start");
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_back_to_back_read();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of rxd synchronizer flops (legal values 2 or 3).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; all state is cleared while rst is 0.
REQ-004 rxd  input  1  serial receive line; idle high; asynchronous to clk.
REQ-005 divisor  input  16  sample-tick period minus one, in clk cycles; one bit time = 16 sample ticks.
REQ-006 rd_en  input  1  single-cycle read strobe; acknowledges the held byte.
REQ-007 rx_data  output  8  last received byte.
REQ-008 rda  output  1  receive data available.
REQ-009 frame_err  output  1  stop bit of the held byte sampled low.
REQ-010 overrun  output  1  a byte completed while rda was already 1.

Function
REQ-011 rxd SHALL pass through SYNC_STAGES flops; every flop resets to 1; all sampling uses the last flop (rxd_s).
REQ-012 Tick generator: 16-bit down counter; tick on the cycle it reads 0, then it reloads divisor; otherwise it decrements; tick period = divisor+1 cycles.
REQ-013 divisor = 0 SHALL give a tick every cycle; a divisor change takes effect at the next reload only.
REQ-014 FSM states IDLE, START, DATA, STOP; all state changes only on tick cycles.
REQ-015 IDLE: tick with rxd_s=0 and armed=1 -> START, sample count cleared; armed is set by any tick with rxd_s=1 and cleared on leaving IDLE.
REQ-016 START: on the 8th tick (mid start bit), rxd_s=0 -> DATA with bit and sample counts cleared; rxd_s=1 -> IDLE (glitch rejected, no output change).
REQ-017 DATA: every 16th tick, rxd_s is shifted into the shift register LSB-first; after the 8th bit -> STOP.
REQ-018 STOP: on the 16th tick, rxd_s is sampled; FSM -> IDLE.
REQ-019 Byte completion (STOP sample cycle): on the next clk edge rx_data <= shift register, rda <= 1, frame_err <= ~rxd_s; latency = 1 clk after the stop-sample tick.
REQ-020 frame_err=1 SHALL still deliver the byte; armed stays 0 until the line returns high, so a break is never read as a new start.
REQ-021 Completion with rda=1 and rd_en=0 SHALL set overrun=1 and overwrite rx_data and frame_err.
REQ-022 rd_en with no completion in the same cycle SHALL clear rda, frame_err and overrun on the next edge; rx_data holds.
REQ-023 rd_en coincident with completion: new byte is loaded, rda stays 1, overrun=0, frame_err reflects the new byte.
REQ-024 rd_en with rda=0 SHALL have no effect.
REQ-025 The shift register, counters and armed SHALL not be affected by rd_en.

Reset
REQ-026 While rst=0: FSM=IDLE, armed=0, sample/bit counts=0, tick counter=0, shift register=0, rx_data=8'h00, rda=0, frame_err=0, overrun=0, synchronizer=all 1.
REQ-027 Assertion mid-frame SHALL abort the frame with no partial byte delivered; after release a new frame is received only after one tick of idle-high line.

Verification
REQ-028 divisor=1, send 0xA5 (start 0, LSB-first, stop 1, 32 clk/bit) -> rda=1 and rx_data=8'hA5, frame_err=0, overrun=0, one clk after the stop-sample tick.
REQ-029 divisor=1, 0-pulse of 6 clk on an idle line -> START entered, back to IDLE at mid-bit; rda stays 0, rx_data unchanged.
REQ-030 divisor=0, send 0x3C with stop bit driven 0, then line held 0 for 40 bits -> rx_data=8'h3C, rda=1, frame_err=1; no second byte until line goes high.
REQ-031 divisor=1, send 0x11 then 0x22 with no rd_en -> rx_data=8'h22, rda=1, overrun=1; single rd_en -> rda, overrun, frame_err all 0.
REQ-032 rd_en pulsed on the exact completion cycle of 0x7E while 0x11 held -> rx_data=8'h7E, rda=1, overrun=0.
REQ-033 rst pulled low mid-DATA of 0xFF, released, then 0x81 sent -> rda=1, rx_data=8'h81 only; no byte from the aborted frame.
